multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OPCODE_W, default 3: opcode width; encodings 0-5 fixed, all other values illegal.
REQ-002 Parameter MEM_TIMEOUT, default 15: maximum wait cycles for mem_ready; 0 disables the timeout.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous and active-low.
REQ-005 opcode  in  OPCODE_W  opcode field of the instruction register; valid from DECODE onward.
REQ-006 eq_out  in  1  comparator result from the datapath.
REQ-007 mem_ready  in  1  memory handshake completion; sampled only while mem_req=1.
REQ-008 mem_req  out  1  memory access request, held until mem_ready or timeout.
REQ-009 ir_we, pc_we  out  1 each  instruction register load and PC load strobes.
REQ-010 ADD, NAND, PASS1, EQ  out  1 each  one-hot datapath operation selects.
REQ-011 we_reg, we_mem, BR  out  1 each  register write, memory write, taken branch.
REQ-012 mem_err  out  1  one-cycle pulse on memory timeout.
REQ-013 illegal  out  1  illegal-opcode indication (see Configuration).
REQ-014 state  out  3  current FSM state code, for debug.

Function
REQ-015 FSM states and codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-016 FETCH behaviour:
- mem_req=1.
- On mem_ready: ir_we=1 and pc_we=1 for that cycle, then go to DECODE.
- Otherwise stay in FETCH.
REQ-017 DECODE: latch opcode into internal op_q, then go to EXEC unconditionally.
REQ-018 EXEC with op_q 0 (ADD), 1 (NAND) or 2 (PASS1): assert the matching select, then go to WB.
REQ-019 EXEC with op_q 3 (BEQ):
- EQ=1 and BR=eq_out.
- pc_we=eq_out.
- Then go to FETCH.
REQ-020 EXEC with op_q 4 (SW) or 5 (LW): go to MEM.
REQ-021 MEM behaviour:
- mem_req=1; we_mem=1 while op_q=SW.
- On mem_ready: SW goes to FETCH, LW goes to WB.
- Otherwise stay in MEM.
REQ-022 WB:
- we_reg=1 for exactly one cycle.
- Op select of op_q (ADD/NAND/PASS1) held; none for LW.
- Then go to FETCH.
REQ-023 Outputs are decoded from state and op_q only, except BR and pc_we in EXEC, which also depend on eq_out.
REQ-024 Select outputs not named for a state are 0.
REQ-025 Latency with zero-wait memory: ALU ops and SW take 4 cycles, BEQ takes 3 cycles, LW takes 5 cycles, measured FETCH to FETCH.
REQ-026 Wait counter:
- Increments each cycle mem_req=1 and mem_ready=0.
- Clears on state change.
- Saturates at MEM_TIMEOUT.
REQ-027 Timeout: when the counter equals MEM_TIMEOUT (nonzero) and mem_ready=0, assert mem_err for one cycle and go to FETCH.
- From MEM: the access is abandoned, with no WB and no PC change.
- From FETCH: the fetch is retried.
REQ-028 mem_ready in the same cycle as a timeout is treated as completion; mem_err=0.
REQ-029 mem_ready while mem_req=0 is ignored.
REQ-030 opcode changes after DECODE have no effect; op_q governs.

Reset
REQ-031 rst_n low immediately forces:
- state to FETCH;
- op_q and the wait counter to 0;
- all outputs to 0, including mem_req, with state=0.
REQ-032 mem_req rises in the first clock cycle after rst_n deasserts.
REQ-033 Reset mid-access abandons the access with no write strobe.

Configuration
REQ-034 Macro CTRL_ILLEGAL_TRAP_EN controls illegal-opcode handling.
- Defined: EXEC with an illegal op_q asserts illegal=1 and goes to TRAP.
- TRAP holds all strobes at 0 and illegal=1 until reset.
- Not defined: illegal opcodes are no-ops (EXEC goes to FETCH), illegal is tied to 0, and TRAP is unreachable.

Verification
REQ-035 Reset release, mem_ready=1 constant, opcode=0 -> FETCH,DECODE,EXEC,WB repeat; we_reg high every 4th cycle with ADD=1.
REQ-036 BEQ case (opcode=3):
- eq_out=1 -> BR=1 and pc_we=1 in EXEC, next state FETCH.
- eq_out=0 -> BR=0 and pc_we=0.
REQ-037 LW with mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles, WB follows, we_mem never 1.
REQ-038 SW with mem_ready never asserted, MEM_TIMEOUT=15 -> mem_err pulse after 15 wait cycles, return to FETCH, we_reg never 1.
REQ-039 opcode=7:
- With CTRL_ILLEGAL_TRAP_EN -> state=5 and illegal=1 held; rst_n low clears both.
- Without the macro -> FETCH after EXEC with illegal=0.
REQ-040 rst_n pulsed low during MEM of SW -> we_mem and mem_req drop immediately; restart at FETCH.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB(/TRAP) sequencing with memory wait timeout.
// Latency: ALU/SW 4 cycles, BEQ 3, LW 5 (zero-wait memory); outputs are combinational from state/op_q.
// Backpressure: mem_req held in FETCH/MEM until mem_ready or MEM_TIMEOUT wait cycles (mem_err pulse).
//
// Ports:
//   clk, rst_n (async active-low), opcode, eq_out, mem_ready  -- inputs
//   mem_req, ir_we, pc_we, ADD, NAND, PASS1, EQ, we_reg, we_mem, BR, mem_err, illegal, state -- outputs
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes in TRAP until reset.
module multicycle_control #(
    parameter int OPCODE_W    = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                eq_out,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                ir_we,
    output logic                pc_we,
    output logic                ADD,
    output logic                NAND,
    output logic                PASS1,
    output logic                EQ,
    output logic                we_reg,
    output logic                we_mem,
    output logic                BR,
    output logic                mem_err,
    output logic                illegal,
    output logic [2:0]          state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_NAND  = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_PASS1 = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(5);

    localparam int               CNT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TMO    = CNT_W'(MEM_TIMEOUT);
    localparam logic             TMO_EN = (MEM_TIMEOUT != 0);

    logic [2:0]          r_state;
    logic [OPCODE_W-1:0] r_op_q;
    logic [CNT_W-1:0]    r_cnt;

    logic [2:0]          w_state_nxt;
    logic                w_mem_req;
    logic                w_timeout;

    assign w_mem_req = (r_state == S_FETCH) || (r_state == S_MEM);
    // mem_ready in the timeout cycle wins: it is a completion, not an error.
    assign w_timeout = TMO_EN && w_mem_req && !mem_ready && (r_cnt == TMO);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)      w_state_nxt = S_DECODE;
                else if (w_timeout) w_state_nxt = S_FETCH;   // retry the fetch
            end
            S_DECODE: w_state_nxt = S_EXEC;
            S_EXEC: begin
                case (r_op_q)
                    OP_ADD, OP_NAND, OP_PASS1: w_state_nxt = S_WB;
                    OP_BEQ:                    w_state_nxt = S_FETCH;
                    OP_SW, OP_LW:              w_state_nxt = S_MEM;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:                   w_state_nxt = S_TRAP;
`else
                    default:                   w_state_nxt = S_FETCH;
`endif
                endcase
            end
            S_MEM: begin
                if (mem_ready)      w_state_nxt = (r_op_q == OP_SW) ? S_FETCH : S_WB;
                else if (w_timeout) w_state_nxt = S_FETCH;   // abandon access, no WB
            end
            S_WB: w_state_nxt = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP: w_state_nxt = S_TRAP;
`endif
            default: w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_op_q  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_DECODE) begin
                r_op_q <= opcode;
            end
            // A FETCH retry keeps the state code, so the timeout also clears the count.
            if ((w_state_nxt != r_state) || w_timeout) begin
                r_cnt <= '0;
            end else if (w_mem_req && !mem_ready && (r_cnt != TMO)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Outputs are gated by rst_n so everything, including mem_req, drops the
    // moment reset asserts rather than at the next clock.
    always_comb begin
        mem_req = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        ADD     = 1'b0;
        NAND    = 1'b0;
        PASS1   = 1'b0;
        EQ      = 1'b0;
        we_reg  = 1'b0;
        we_mem  = 1'b0;
        BR      = 1'b0;
        mem_err = 1'b0;
        illegal = 1'b0;
        state   = rst_n ? r_state : S_FETCH;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                    pc_we   = mem_ready;
                    mem_err = w_timeout;
                end
                S_EXEC: begin
                    case (r_op_q)
                        OP_ADD:   ADD   = 1'b1;
                        OP_NAND:  NAND  = 1'b1;
                        OP_PASS1: PASS1 = 1'b1;
                        OP_BEQ: begin
                            EQ    = 1'b1;
                            BR    = eq_out;
                            pc_we = eq_out;
                        end
                        OP_SW, OP_LW: ;
                        default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                            illegal = 1'b1;
`endif
                        end
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    we_mem  = (r_op_q == OP_SW);
                    mem_err = w_timeout;
                end
                S_WB: begin
                    we_reg = 1'b1;
                    ADD    = (r_op_q == OP_ADD);
                    NAND   = (r_op_q == OP_NAND);
                    PASS1  = (r_op_q == OP_PASS1);
                end
`ifdef CTRL_ILLEGAL_TRAP_EN
                S_TRAP: illegal = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: linear step sequence, immediate assertions per step.
// Inputs change just after the falling edge; outputs are checked 1 ns later.
// Expected state/strobe vectors are hand-written constants per step.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] opcode;
    logic       eq_out;
    logic       mem_ready;
    logic       mem_req, ir_we, pc_we, ADD, NAND, PASS1, EQ;
    logic       we_reg, we_mem, BR, mem_err, illegal;
    logic [2:0] state;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] TRAP   = 3'd5;

    localparam logic [11:0] NONE  = 12'h000;
    localparam logic [11:0] MREQ  = 12'h800;
    localparam logic [11:0] IRWE  = 12'h400;
    localparam logic [11:0] PCWE  = 12'h200;
    localparam logic [11:0] SADD  = 12'h100;
    localparam logic [11:0] SNAND = 12'h080;
    localparam logic [11:0] SPASS = 12'h040;
    localparam logic [11:0] SEQ   = 12'h020;
    localparam logic [11:0] WREG  = 12'h010;
    localparam logic [11:0] WMEM  = 12'h008;
    localparam logic [11:0] BRT   = 12'h004;
    localparam logic [11:0] MERR  = 12'h002;
    localparam logic [11:0] ILL   = 12'h001;
    localparam logic [11:0] FOK   = MREQ | IRWE | PCWE;

    logic [14:0] obs;
    assign obs = {state, mem_req, ir_we, pc_we, ADD, NAND, PASS1, EQ,
                  we_reg, we_mem, BR, mem_err, illegal};

    multicycle_control #(
        .OPCODE_W    (3),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .eq_out    (eq_out),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .ADD       (ADD),
        .NAND      (NAND),
        .PASS1     (PASS1),
        .EQ        (EQ),
        .we_reg    (we_reg),
        .we_mem    (we_mem),
        .BR        (BR),
        .mem_err   (mem_err),
        .illegal   (illegal),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] st, input logic [11:0] fl);
        logic [14:0] exp_v;
        exp_v = {st, fl};
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed state=%0d flags=%03h, expected state=%0d flags=%03h",
                   tag, obs[14:12], obs[11:0], st, fl);
        end
    endtask

    // Check the current cycle, then advance to the next falling edge.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [11:0] fl);
        #1;
        chk(tag, st, fl);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        opcode    = 3'd0;
        eq_out    = 1'b0;
        mem_ready = 1'b1;

        // Reset: everything low, including mem_req, even with mem_ready high.
        @(negedge clk);
        #1 chk("reset", FETCH, NONE);
        mem_ready = 1'b0;
        rst_n     = 1'b1;
        cyc("post_reset_mem_req", FETCH, MREQ);

        // ALU ops: FETCH, DECODE, EXEC, WB with matching select.
        for (int i = 0; i < 3; i++) begin
            logic [11:0] sel;
            sel       = SADD >> i;
            opcode    = 3'(i);
            mem_ready = 1'b1;
            cyc("alu_fetch", FETCH, FOK);
            cyc("alu_decode", DECODE, NONE);
            cyc("alu_exec", EXEC, sel);
            cyc("alu_wb", WB, sel | WREG);
        end

        // BEQ taken.
        opcode = 3'd3;
        eq_out = 1'b1;
        cyc("beq_t_fetch", FETCH, FOK);
        cyc("beq_t_decode", DECODE, NONE);
        cyc("beq_taken", EXEC, SEQ | BRT | PCWE);

        // BEQ not taken; opcode changed after DECODE must not matter.
        eq_out = 1'b0;
        cyc("beq_n_fetch", FETCH, FOK);
        cyc("beq_n_decode", DECODE, NONE);
        opcode = 3'd0;
        cyc("beq_not_taken", EXEC, SEQ);

        // LW with mem_ready delayed 3 cycles in MEM.
        opcode = 3'd5;
        cyc("lw_fetch", FETCH, FOK);
        cyc("lw_decode", DECODE, NONE);
        cyc("lw_exec", EXEC, NONE);
        mem_ready = 1'b0;
        repeat (3) cyc("lw_wait", MEM, MREQ);
        mem_ready = 1'b1;
        cyc("lw_done", MEM, MREQ);
        cyc("lw_wb", WB, WREG);

        // SW with no mem_ready: 15 wait cycles then timeout, back to FETCH.
        opcode = 3'd4;
        cyc("sw_fetch", FETCH, FOK);
        cyc("sw_decode", DECODE, NONE);
        cyc("sw_exec", EXEC, NONE);
        mem_ready = 1'b0;
        repeat (15) cyc("sw_wait", MEM, MREQ | WMEM);
        cyc("sw_timeout", MEM, MREQ | WMEM | MERR);
        cyc("sw_abandon", FETCH, MREQ);

        // FETCH timeout retries; counter restarts after the retry.
        repeat (14) cyc("fetch_wait", FETCH, MREQ);
        cyc("fetch_timeout", FETCH, MREQ | MERR);
        cyc("fetch_retry", FETCH, MREQ);
        repeat (14) cyc("fetch_wait2", FETCH, MREQ);
        // Ready coincident with the timeout count is a completion.
        mem_ready = 1'b1;
        opcode    = 3'd7;
        cyc("fetch_late_ready", FETCH, FOK);
        cyc("ill_decode", DECODE, NONE);

`ifdef CTRL_ILLEGAL_TRAP_EN
        cyc("ill_exec", EXEC, ILL);
        cyc("ill_trap", TRAP, ILL);
        cyc("ill_hold", TRAP, ILL);
        #1 rst_n = 1'b0;
        #1 chk("ill_reset", FETCH, NONE);
        @(negedge clk);
        rst_n = 1'b1;
`else
        cyc("ill_exec", EXEC, NONE);
`endif

        // SW interrupted by reset while in MEM.
        opcode    = 3'd4;
        mem_ready = 1'b1;
        cyc("sw2_fetch", FETCH, FOK);
        cyc("sw2_decode", DECODE, NONE);
        cyc("sw2_exec", EXEC, NONE);
        mem_ready = 1'b0;
        cyc("sw2_mem", MEM, MREQ | WMEM);
        #1 chk("sw2_mem_hold", MEM, MREQ | WMEM);
        #1 rst_n = 1'b0;
        #1 chk("rst_mid_mem", FETCH, NONE);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("rst_restart", FETCH, MREQ);
        mem_ready = 1'b1;
        opcode    = 3'd0;
        cyc("restart_fetch", FETCH, FOK);
        cyc("restart_decode", DECODE, NONE);
        cyc("restart_exec", EXEC, SADD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
